sw_debounce: RTL
================

# sw_debounce

Input-side conditioner for the board's slide switches: synchronizes the asynchronous `i_sw` pins into `clock`, debounces each bit with a per-bit stability counter, and emits debounced levels plus one-cycle change strobes. It drives the switch inputs of the LED counter/shift-register path, which currently take raw pins. Its `o_valid` strobe uses the same single-cycle pulse convention as the counter's strobe into the shift register.

## Interface
- `NB_SW`, 4, number of switch bits
- `NB_DEBOUNCE`, 20, width of each per-bit stability counter
- `DEBOUNCE_CYCLES`, 1_000_000, consecutive stable cycles required to accept a new level
  - Legal range is 1 .. 2^NB_DEBOUNCE-1.
- `clock`  input  1  system clock; all logic on the rising edge
- `i_reset`  input  1  asynchronous, active-low reset
  - Asserts immediately.
  - Deasserts synchronously to `clock` through the top-level reset path.
- `i_sw`  input  NB_SW  raw switch pins, asynchronous to `clock`
- `o_sw`  output  NB_SW  debounced switch levels
- `o_rise`  output  NB_SW  one-cycle pulse per bit on a debounced 0→1 change
- `o_fall`  output  NB_SW  one-cycle pulse per bit on a debounced 1→0 change
- `o_valid`  output  1  one-cycle pulse when any bit of `o_sw` changes

## Operation
- Synchronizer: two flops per bit, `sync1` then `sync2`. Both reset to 0. `sync2` is the sample `s`.
- Each bit has an independent FSM and counter `cnt` of width NB_DEBOUNCE.
- State STABLE (reset state, `cnt`=0):
  - If `s` != `o_sw[i]`, go to CHECK with `cnt`=1.
  - Otherwise stay in STABLE.
- State CHECK:
  - If `s` == `o_sw[i]` (glitch), go to STABLE with `cnt`=0. `o_sw[i]` does not change.
  - Else if `cnt` == DEBOUNCE_CYCLES, toggle `o_sw[i]`, go to STABLE, set `cnt`=0, and assert the edge pulse for the next cycle.
  - Otherwise increment `cnt`.
- DEBOUNCE_CYCLES=1 case: `o_sw[i]` toggles on the edge after the first differing sample.
- Counter never wraps: the maximum value is DEBOUNCE_CYCLES, which is below 2^NB_DEBOUNCE.
- `o_rise[i]` / `o_fall[i]`: registered, high exactly one cycle, in the cycle `o_sw[i]` first shows its new value.
- `o_valid` = OR of all `o_rise` and `o_fall` bits, registered alongside them so all three are coincident.
- Bits are fully independent. Several bits toggling on the same edge give a single `o_valid` pulse with several edge bits set.
- Reset values: `o_sw`=0, `o_rise`=0, `o_fall`=0, `o_valid`=0, all FSMs in STABLE, all counters 0.
- Reset asserted mid-CHECK discards progress.
- After reset releases with a switch held at 1: that bit is accepted after the normal latency and produces an `o_rise` pulse.

## Timing
- Reference point: `i_sw[i]` changes before rising edge E0 and then stays stable.
- `s` shows the new value after edge E1.
- `o_sw[i]`, the edge pulse, and `o_valid` change after edge E1+DEBOUNCE_CYCLES+1.
- Total latency is therefore DEBOUNCE_CYCLES+2 edges.
- Any return of `s` to the old level before acceptance restarts the full wait.
- No combinational path from `i_sw` to any output.

## Configuration
- Macro `SW_EDGE_DETECT_EN`.
- Defined: `o_rise`, `o_fall` and `o_valid` behave as described above.
- Not defined:
  - `o_rise`, `o_fall` and `o_valid` are tied to constant 0 and their registers are not built.
  - `o_sw` behaviour and latency are unchanged.
  - The port list is identical in both builds.

## Structure
- Shared package `sw_debounce_pkg` holds:
  - the FSM state encoding (STABLE=1'b0, CHECK=1'b1);
  - the default constants NB_SW, NB_DEBOUNCE, DEBOUNCE_CYCLES.
- Sub-module `sw_debounce_bit`:
  - one instance per bit, generated NB_SW times;
  - contains the synchronizer, FSM, counter, level register and per-bit edge registers.
- Top module: generate loop plus the `o_valid` OR-reduction register.

## Test plan
Run with DEBOUNCE_CYCLES=4, NB_SW=4.
- **Reset:** hold `i_reset`=0 with `i_sw`=4'b1111 → all outputs 0. Release → `o_sw`=4'b1111 exactly 6 edges later, with `o_rise`=4'b1111 and `o_valid`=1 for one cycle.
- **Clean press:** `i_sw[0]` 0→1 held → `o_sw[0]`=1 after 6 edges, one-cycle `o_rise[0]`, `o_fall`=0.
- **Bounce:** `i_sw[1]` toggles 1,0,1,0 every 2 cycles, then holds 1 → no `o_sw[1]` change during bouncing. `o_sw[1]`=1 six edges after the final transition, with exactly one `o_valid` pulse.
- **Simultaneous:** `i_sw` 4'b0000→4'b0101 on one edge → a single `o_valid` pulse with `o_rise`=4'b0101.
- **Reset mid-CHECK:** start a press, assert `i_reset` after 3 cycles → `o_sw` stays 0 and no pulse appears.
- **Macro off:** rerun clean press without `SW_EDGE_DETECT_EN` → `o_sw` timing identical, while `o_rise`, `o_fall` and `o_valid` stay 0 throughout.

Source files
------------

// File: rtl/sw_debounce_pkg.sv
// rtl/sw_debounce_pkg.sv - shared constants and FSM encoding for the switch debouncer
// Default sizing for the debouncer plus the per-bit FSM state type.
// Optional feature macro used by the bundle: SW_EDGE_DETECT_EN.
package sw_debounce_pkg;

    localparam int NB_SW           = 4;
    localparam int NB_DEBOUNCE     = 20;
    localparam int DEBOUNCE_CYCLES = 1_000_000;

    typedef enum logic {
        STABLE = 1'b0,
        CHECK  = 1'b1
    } deb_state_e;

endpackage

// File: rtl/sw_debounce_if.sv
// rtl/sw_debounce_if.sv - switch-side bundle between the pins and the debouncer
// Signals:
//   i_sw    raw switch pins (asynchronous to the debouncer clock)
//   o_sw    debounced levels
//   o_rise  one-cycle pulse per bit on a debounced 0->1 change
//   o_fall  one-cycle pulse per bit on a debounced 1->0 change
//   o_valid one-cycle pulse when any debounced bit changes
// master: the side driving the pins and consuming results; slave: the debouncer.
interface sw_debounce_if
    import sw_debounce_pkg::*;
#(
    parameter int NB_SW_P = NB_SW
) ();

    logic [NB_SW_P-1:0] i_sw;
    logic [NB_SW_P-1:0] o_sw;
    logic [NB_SW_P-1:0] o_rise;
    logic [NB_SW_P-1:0] o_fall;
    logic               o_valid;

    modport master (
        output i_sw,
        input  o_sw,
        input  o_rise,
        input  o_fall,
        input  o_valid
    );

    modport slave (
        input  i_sw,
        output o_sw,
        output o_rise,
        output o_fall,
        output o_valid
    );

endinterface

// File: rtl/sw_debounce_bit.sv
// rtl/sw_debounce_bit.sv - one switch bit: synchronizer, stability FSM/counter, level and edge registers
// Ports:
//   clock     system clock, rising edge
//   i_reset   asynchronous active-low reset
//   o_edge_d  (only with SW_EDGE_DETECT_EN) next-cycle edge indication, lets the
//             top register o_valid coincident with this bit's edge flops
//   i_sw      raw pin
//   o_sw      debounced level
//   o_rise    registered 0->1 pulse (0 when SW_EDGE_DETECT_EN is undefined)
//   o_fall    registered 1->0 pulse (0 when SW_EDGE_DETECT_EN is undefined)
module sw_debounce_bit
    import sw_debounce_pkg::*;
#(
    parameter int NB_DEBOUNCE_P     = NB_DEBOUNCE,
    parameter int DEBOUNCE_CYCLES_P = DEBOUNCE_CYCLES
) (
    input  logic clock,
    input  logic i_reset,
`ifdef SW_EDGE_DETECT_EN
    output logic o_edge_d,
`endif
    input  logic i_sw,
    output logic o_sw,
    output logic o_rise,
    output logic o_fall
);

    localparam logic [NB_DEBOUNCE_P-1:0] CNT_MAX = NB_DEBOUNCE_P'(DEBOUNCE_CYCLES_P);
    localparam logic [NB_DEBOUNCE_P-1:0] CNT_ONE = NB_DEBOUNCE_P'(1);

    logic                     sync1_q, sync1_d;
    logic                     sync2_q, sync2_d;
    deb_state_e               state_q, state_d;
    logic [NB_DEBOUNCE_P-1:0] cnt_q,   cnt_d;
    logic                     sw_q,    sw_d;

    always_ff @(posedge clock or negedge i_reset) begin
        if (!i_reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            state_q <= STABLE;
            cnt_q   <= '0;
            sw_q    <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sw_q    <= sw_d;
        end
    end

    // sync2_q is the clean sample; the pin only ever reaches sync1.
    always_comb begin
        sync1_d = i_sw;
        sync2_d = sync1_q;
        state_d = state_q;
        cnt_d   = cnt_q;
        sw_d    = sw_q;
        case (state_q)
            STABLE: begin
                cnt_d = '0;
                if (sync2_q != sw_q) begin
                    state_d = CHECK;
                    cnt_d   = CNT_ONE;
                end
            end
            CHECK: begin
                if (sync2_q == sw_q) begin
                    // Sample fell back to the accepted level: restart the full wait.
                    state_d = STABLE;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_MAX) begin
                    sw_d    = ~sw_q;
                    state_d = STABLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
        endcase
    end

    assign o_sw = sw_q;

`ifdef SW_EDGE_DETECT_EN
    logic rise_q, rise_d;
    logic fall_q, fall_d;

    // Edge flops load on the same edge as sw_q, so the pulse lines up with the new level.
    always_comb begin
        rise_d   = sw_d & ~sw_q;
        fall_d   = ~sw_d & sw_q;
        o_edge_d = rise_d | fall_d;
    end

    always_ff @(posedge clock or negedge i_reset) begin
        if (!i_reset) begin
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            rise_q <= rise_d;
            fall_q <= fall_d;
        end
    end

    assign o_rise = rise_q;
    assign o_fall = fall_q;
`else
    assign o_rise = 1'b0;
    assign o_fall = 1'b0;
`endif

endmodule

// File: rtl/sw_debounce.sv
// rtl/sw_debounce.sv - slide-switch conditioner: per-bit debouncers plus the shared change strobe
// Ports:
//   clock    system clock, rising edge
//   i_reset  asynchronous active-low reset (release is already synchronous to clock)
//   sw_bus   sw_debounce_if.slave: i_sw in; o_sw, o_rise, o_fall, o_valid out
// Macro SW_EDGE_DETECT_EN builds the edge/valid registers; without it those outputs are 0.
module sw_debounce
    import sw_debounce_pkg::*;
#(
    parameter int NB_SW_P           = NB_SW,
    parameter int NB_DEBOUNCE_P     = NB_DEBOUNCE,
    parameter int DEBOUNCE_CYCLES_P = DEBOUNCE_CYCLES
) (
    input  logic        clock,
    input  logic        i_reset,
    sw_debounce_if.slave sw_bus
);

    logic [NB_SW_P-1:0] sw_lvl;
    logic [NB_SW_P-1:0] sw_rise;
    logic [NB_SW_P-1:0] sw_fall;
`ifdef SW_EDGE_DETECT_EN
    logic [NB_SW_P-1:0] edge_d;
`endif

    for (genvar i = 0; i < NB_SW_P; i++) begin : g_bit
        sw_debounce_bit #(
            .NB_DEBOUNCE_P     (NB_DEBOUNCE_P),
            .DEBOUNCE_CYCLES_P (DEBOUNCE_CYCLES_P)
        ) u_bit (
            .clock    (clock),
            .i_reset  (i_reset),
`ifdef SW_EDGE_DETECT_EN
            .o_edge_d (edge_d[i]),
`endif
            .i_sw     (sw_bus.i_sw[i]),
            .o_sw     (sw_lvl[i]),
            .o_rise   (sw_rise[i]),
            .o_fall   (sw_fall[i])
        );
    end

    assign sw_bus.o_sw   = sw_lvl;
    assign sw_bus.o_rise = sw_rise;
    assign sw_bus.o_fall = sw_fall;

`ifdef SW_EDGE_DETECT_EN
    logic valid_q, valid_d;

    // Built from the bits' next-cycle edges so o_valid rises with o_rise/o_fall.
    always_comb begin
        valid_d = |edge_d;
    end

    always_ff @(posedge clock or negedge i_reset) begin
        if (!i_reset) begin
            valid_q <= 1'b0;
        end else begin
            valid_q <= valid_d;
        end
    end

    assign sw_bus.o_valid = valid_q;
`else
    assign sw_bus.o_valid = 1'b0;
`endif

endmodule
